// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: default geometry,
// pointer-width derivation and the buffer entry layout.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_ABITS = 11;
    localparam int SB_DBITS = 32;

    // Pointer width for a power-of-two entry count.
    function automatic int sb_pbits(input int depth);
        return $clog2(depth);
    endfunction

    localparam int SB_PBITS = sb_pbits(SB_DEPTH);

    // One buffered store. Field widths follow SB_ABITS/SB_DBITS.
    typedef struct packed {
        logic                valid;
        logic [SB_ABITS-1:0] addr;
        logic [SB_DBITS-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// sb_match: DEPTH-way load address compare against the buffer entries with a
// youngest-first priority select. Age is measured backwards from the tail, so
// the entry just before tail is youngest and the entry at tail (when full) is
// oldest.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int ABITS = SB_ABITS,
    parameter int PBITS = sb_pbits(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [ABITS-1:0] addr_i [DEPTH],
    input  logic [ABITS-1:0] ld_addr_i,
    input  logic [PBITS-1:0] tail_i,
    output logic             hit_o,
    output logic [PBITS-1:0] hit_idx_o
);

    logic [PBITS-1:0] idx;

    // Walk oldest to youngest so that a younger match overrides an older one.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        idx       = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PBITS'(k);
            if (valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order word-store FIFO sitting in front of the data array's
// single write port, with a combinational load probe for younger loads.
// Optional feature macro: STORE_BUFFER_FWD_EN enables data forwarding on
// LD_DATA; without it LD_DATA is tied to 0 and LD_HIT acts as a stall hint.
// DBITS/ABITS must equal the package entry widths.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DBITS = SB_DBITS,
    parameter int ABITS = SB_ABITS,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ST_VALID,
    output logic                   ST_READY,
    input  logic [ABITS-1:0]       ST_ADDR,
    input  logic [DBITS-1:0]       ST_DATA,
    input  logic [ABITS-1:0]       LD_ADDR,
    output logic                   LD_HIT,
    output logic [DBITS-1:0]       LD_DATA,
    input  logic                   MEM_GRANT,
    output logic                   MEM_WE,
    output logic [ABITS-1:0]       MEM_ADDR,
    output logic [DBITS-1:0]       MEM_DIN,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT
);

    localparam int              PBITS      = sb_pbits(DEPTH);
    localparam logic [PBITS:0]  FULL_COUNT = (PBITS+1)'(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PBITS-1:0] head_q, head_d;
    logic [PBITS-1:0] tail_q, tail_d;
    logic [PBITS:0]   count_q, count_d;

    logic             enq;
    logic             deq;
    logic             empty;
    logic [DEPTH-1:0] valid_vec;
    logic [ABITS-1:0] addr_vec [DEPTH];
    logic             hit;
    logic [PBITS-1:0] hit_idx;

    // Store handshake: a store transfers on a cycle with ST_VALID && ST_READY.
    // ST_READY depends only on the registered count, never on MEM_GRANT.
    assign empty    = (count_q == '0);
    assign ST_READY = !RESET && (count_q != FULL_COUNT);
    assign enq      = ST_VALID && ST_READY;
    assign deq      = !RESET && !empty && MEM_GRANT;

    assign MEM_WE   = deq;
    assign MEM_ADDR = entries_q[head_q].addr;
    assign MEM_DIN  = entries_q[head_q].data;
    assign EMPTY    = RESET || empty;
    assign COUNT    = RESET ? '0 : count_q;

    // Flatten entry fields for the matcher.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            addr_vec[i]  = entries_q[i].addr;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .ABITS (ABITS),
        .PBITS (PBITS)
    ) u_match (
        .valid_i   (valid_vec),
        .addr_i    (addr_vec),
        .ld_addr_i (LD_ADDR),
        .tail_i    (tail_q),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    assign LD_HIT = !RESET && hit;

`ifdef STORE_BUFFER_FWD_EN
    assign LD_DATA = (!RESET && hit) ? entries_q[hit_idx].data : '0;
`else
    logic unused_hit_idx;
    assign unused_hit_idx = ^hit_idx;
    assign LD_DATA        = '0;
`endif

    // Next-state: drain clears the head entry, enqueue fills the tail entry.
    // Head and tail only coincide when empty (no drain) or full (no enqueue).
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (deq) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (enq) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: ST_ADDR, data: ST_DATA};
            tail_d            = tail_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register; reset discards every pending store.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer. Builds with or without STORE_BUFFER_FWD_EN;
// expected LD_DATA follows the same macro.
module tb_store_buffer;

    localparam int DBITS = 32;
    localparam int ABITS = 11;
    localparam int DEPTH = 4;
    localparam int EW    = ABITS + DBITS;

    logic             CLK;
    logic             RESET;
    logic             ST_VALID;
    logic             ST_READY;
    logic [ABITS-1:0] ST_ADDR;
    logic [DBITS-1:0] ST_DATA;
    logic [ABITS-1:0] LD_ADDR;
    logic             LD_HIT;
    logic [DBITS-1:0] LD_DATA;
    logic             MEM_GRANT;
    logic             MEM_WE;
    logic [ABITS-1:0] MEM_ADDR;
    logic [DBITS-1:0] MEM_DIN;
    logic             EMPTY;
    logic [2:0]       COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];

    store_buffer #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ST_VALID  (ST_VALID),
        .ST_READY  (ST_READY),
        .ST_ADDR   (ST_ADDR),
        .ST_DATA   (ST_DATA),
        .LD_ADDR   (LD_ADDR),
        .LD_HIT    (LD_HIT),
        .LD_DATA   (LD_DATA),
        .MEM_GRANT (MEM_GRANT),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DIN   (MEM_DIN),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected forwarded data for the current build.
    function automatic logic [DBITS-1:0] fwd(input logic [DBITS-1:0] d);
`ifdef STORE_BUFFER_FWD_EN
        return d;
`else
        return '0;
`endif
    endfunction

    // Scoreboard: every memory write must match the oldest expected store.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            logic [EW-1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL mem_write unexpected: addr=%h din=%h, required no write", MEM_ADDR, MEM_DIN);
            end else begin
                e = exp_q.pop_front();
                if ({MEM_ADDR, MEM_DIN} !== e)
                    $display("FAIL mem_write order: addr=%h din=%h, required addr=%h din=%h",
                             MEM_ADDR, MEM_DIN, e[EW-1:DBITS], e[DBITS-1:0]);
                else
                    n_pass++;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_store(input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
        ST_VALID = 1'b1;
        ST_ADDR  = a;
        ST_DATA  = d;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %h, required %h", name, got, want);
        else n_pass++;
    endtask

    task automatic drain_all(input string name);
        MEM_GRANT = 1'b1;
        ST_VALID  = 1'b0;
        for (int i = 0; i < 20 && EMPTY !== 1'b1; i++) tick();
        MEM_GRANT = 1'b0;
        #1;
        n_checks++;
        if (EMPTY !== 1'b1) $display("FAIL %s drain timeout: EMPTY=%b, required 1", name, EMPTY);
        else n_pass++;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        chk("reset st_ready", 64'(ST_READY), 64'd0);
        chk("reset mem_we", 64'(MEM_WE), 64'd0);
        chk("reset empty", 64'(EMPTY), 64'd1);
        chk("reset count", 64'(COUNT), 64'd0);
        chk("reset ld_hit", 64'(LD_HIT), 64'd0);
        chk("reset ld_data", 64'(LD_DATA), 64'd0);
        RESET = 1'b0;
        #1;
        chk("post reset st_ready", 64'(ST_READY), 64'd1);
        chk("post reset count", 64'(COUNT), 64'd0);
    endtask

    task automatic test_single();
        drive_store(11'h010, 32'hDEADBEEF);
        exp_q.push_back({11'h010, 32'hDEADBEEF});
        tick();
        ST_VALID = 1'b0;
        LD_ADDR  = 11'h010;
        #1;
        chk("single count", 64'(COUNT), 64'd1);
        chk("single ld_hit", 64'(LD_HIT), 64'd1);
        chk("single ld_data", 64'(LD_DATA), 64'(fwd(32'hDEADBEEF)));
        chk("single mem_we held", 64'(MEM_WE), 64'd0);
        MEM_GRANT = 1'b1;
        #1;
        chk("single mem_we", 64'(MEM_WE), 64'd1);
        chk("single mem_addr", 64'(MEM_ADDR), 64'h010);
        chk("single mem_din", 64'(MEM_DIN), 64'hDEADBEEF);
        tick();
        chk("single after mem_we", 64'(MEM_WE), 64'd0);
        chk("single after empty", 64'(EMPTY), 64'd1);
        chk("single after ld_hit", 64'(LD_HIT), 64'd0);
        MEM_GRANT = 1'b0;
    endtask

    task automatic test_fill();
        MEM_GRANT = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_store(ABITS'(i), 32'h100 + 32'(i));
            #1;
            chk("fill st_ready", 64'(ST_READY), 64'd1);
            exp_q.push_back({ABITS'(i), 32'h100 + 32'(i)});
            tick();
        end
        drive_store(11'h005, 32'h105);
        #1;
        chk("fill count full", 64'(COUNT), 64'd4);
        chk("fill st_ready full", 64'(ST_READY), 64'd0);
        MEM_GRANT = 1'b1;
        #1;
        chk("fill st_ready full+grant", 64'(ST_READY), 64'd0);
        chk("fill mem_we full", 64'(MEM_WE), 64'd1);
        tick();
        chk("fill count after drain", 64'(COUNT), 64'd3);
        chk("fill st_ready after drain", 64'(ST_READY), 64'd1);
        exp_q.push_back({11'h005, 32'h105});
        tick();
        drain_all("fill");
    endtask

    task automatic test_wrap_stream();
        MEM_GRANT = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_store(11'h040 + ABITS'(i), 32'h5000 + 32'(i));
            exp_q.push_back({11'h040 + ABITS'(i), 32'h5000 + 32'(i)});
            tick();
            chk("stream mem_we", 64'(MEM_WE), 64'd1);
            chk("stream mem_addr", 64'(MEM_ADDR), 64'h040 + 64'(i));
            chk("stream count", 64'(COUNT), 64'd1);
        end
        ST_VALID = 1'b0;
        tick();
        chk("stream empty", 64'(EMPTY), 64'd1);
        chk("stream mem_we idle", 64'(MEM_WE), 64'd0);
        MEM_GRANT = 1'b0;
    endtask

    task automatic test_same_addr();
        MEM_GRANT = 1'b0;
        drive_store(11'h020, 32'h1);
        exp_q.push_back({11'h020, 32'h1});
        tick();
        drive_store(11'h020, 32'h2);
        exp_q.push_back({11'h020, 32'h2});
        tick();
        ST_VALID = 1'b0;
        LD_ADDR  = 11'h021;
        #1;
        chk("same miss ld_hit", 64'(LD_HIT), 64'd0);
        LD_ADDR = 11'h020;
        #1;
        chk("same ld_hit", 64'(LD_HIT), 64'd1);
        chk("same ld_data youngest", 64'(LD_DATA), 64'(fwd(32'h2)));
        chk("same count", 64'(COUNT), 64'd2);
        MEM_GRANT = 1'b1;
        tick();
        MEM_GRANT = 1'b0;
        #1;
        chk("same count after drain", 64'(COUNT), 64'd1);
        chk("same ld_hit after drain", 64'(LD_HIT), 64'd1);
        chk("same ld_data after drain", 64'(LD_DATA), 64'(fwd(32'h2)));
        drain_all("same");
    endtask

    // Head/tail sit at index 2 here, so the two matching entries land at
    // indices 3 and 0: the younger one has the lower index.
    task automatic test_wrap_priority();
        MEM_GRANT = 1'b0;
        drive_store(11'h0AA, 32'h0AA0);
        exp_q.push_back({11'h0AA, 32'h0AA0});
        tick();
        drive_store(11'h030, 32'hAAAA_0001);
        exp_q.push_back({11'h030, 32'hAAAA_0001});
        tick();
        drive_store(11'h030, 32'hBBBB_0002);
        exp_q.push_back({11'h030, 32'hBBBB_0002});
        tick();
        ST_VALID = 1'b0;
        LD_ADDR  = 11'h030;
        #1;
        chk("wrapprio ld_hit", 64'(LD_HIT), 64'd1);
        chk("wrapprio ld_data", 64'(LD_DATA), 64'(fwd(32'hBBBB_0002)));
        LD_ADDR = 11'h0AA;
        #1;
        chk("wrapprio oldest ld_data", 64'(LD_DATA), 64'(fwd(32'h0AA0)));
        drain_all("wrapprio");
    endtask

    task automatic test_reset_mid();
        MEM_GRANT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(11'h060 + ABITS'(i), 32'h6000 + 32'(i));
            tick();
        end
        ST_VALID = 1'b0;
        #1;
        chk("rstmid count before", 64'(COUNT), 64'd3);
        RESET     = 1'b1;
        MEM_GRANT = 1'b1;
        #1;
        chk("rstmid mem_we during", 64'(MEM_WE), 64'd0);
        chk("rstmid st_ready during", 64'(ST_READY), 64'd0);
        tick();
        RESET = 1'b0;
        #1;
        chk("rstmid empty", 64'(EMPTY), 64'd1);
        chk("rstmid count", 64'(COUNT), 64'd0);
        chk("rstmid st_ready", 64'(ST_READY), 64'd1);
        for (int i = 0; i < 3; i++) begin
            LD_ADDR = 11'h060 + ABITS'(i);
            #1;
            chk("rstmid ld_hit", 64'(LD_HIT), 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            chk("rstmid mem_we", 64'(MEM_WE), 64'd0);
            tick();
        end
        MEM_GRANT = 1'b0;
    endtask

    task automatic test_fwd_cfg();
        MEM_GRANT = 1'b0;
        drive_store(11'h070, 32'h1234_5678);
        exp_q.push_back({11'h070, 32'h1234_5678});
        tick();
        ST_VALID = 1'b0;
        LD_ADDR  = 11'h070;
        #1;
        chk("fwdcfg ld_hit", 64'(LD_HIT), 64'd1);
        chk("fwdcfg ld_data", 64'(LD_DATA), 64'(fwd(32'h1234_5678)));
        drain_all("fwdcfg");
    endtask

    initial begin
        RESET     = 1'b1;
        ST_VALID  = 1'b0;
        ST_ADDR   = '0;
        ST_DATA   = '0;
        LD_ADDR   = '0;
        MEM_GRANT = 1'b0;

        test_reset();
        test_single();
        test_fill();
        test_wrap_stream();
        test_same_addr();
        test_wrap_priority();
        test_reset_mid();
        test_fwd_cfg();

        tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard leftover: %0d entries, required 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-store buffer between the pipeline's memory stage and the data memory array's single write port. It accepts stores from the pipeline in order, holds up to DEPTH of them, and drains them one per granted cycle into the array's write port (address port 1, data-in, write enable). Younger loads probe it so they see stores not yet written to the array. Stores therefore never stall on write-port contention, only on a full buffer.

## Interface
- DBITS, 32, data word width; must match the memory array.
- ABITS, 11, word-address width; must match the memory array.
- DEPTH, 4, number of entries; power of two, ≥2.
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- ST_VALID  in  1  store request this cycle.
- ST_READY  out  1  buffer can accept a store this cycle.
- ST_ADDR  in  ABITS  store word address.
- ST_DATA  in  DBITS  store data.
- LD_ADDR  in  ABITS  load word address to probe.
- LD_HIT  out  1  some valid entry matches LD_ADDR.
- LD_DATA  out  DBITS  data of the youngest matching entry.
- MEM_GRANT  in  1  write port free for the buffer this cycle.
- MEM_WE  out  1  write enable to the memory array.
- MEM_ADDR  out  ABITS  write address (head entry).
- MEM_DIN  out  DBITS  write data (head entry).
- EMPTY  out  1  no valid entries.
- COUNT  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Circular FIFO: head pointer, tail pointer and count, each PBITS=$clog2(DEPTH) bits except count (PBITS+1). Pointers wrap modulo DEPTH naturally.
- Enqueue when ST_VALID && ST_READY: entry[tail] gets {addr, data, valid=1}; tail+1; count+1.
- ST_READY = !RESET && (COUNT != DEPTH). It does not depend on a same-cycle drain, so there is no combinational path from MEM_GRANT to ST_READY.
- Drain: MEM_WE = !RESET && !EMPTY && MEM_GRANT. MEM_ADDR/MEM_DIN always show entry[head], and are driven straight from flops. On a drain edge, valid[head] is cleared, head+1 and count−1.
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Store order to memory equals acceptance order. Duplicate addresses are kept as separate entries and are never merged.
- Load probe (combinational): compare LD_ADDR with every valid entry. The youngest match, nearest to tail, wins. The head entry being drained this cycle still participates. A store being enqueued in the same cycle does not participate.
- Reset: on any posedge with RESET=1, all valid bits, pointers and count go to 0. Pending stores are discarded, including after a reset mid-drain. Output values during and after reset: ST_READY=0 during reset and 1 after it; MEM_WE=0; EMPTY=1; COUNT=0; LD_HIT=0; LD_DATA=0. MEM_ADDR/MEM_DIN are don't-care while EMPTY.

## Timing
- Enqueue-to-drain latency: one cycle minimum. A store accepted at edge N can be written to memory at edge N+1 if MEM_GRANT=1 in that cycle.
- Forwarding latency: zero cycles after acceptance. A load probed in the cycle after acceptance hits.
- Throughput: one enqueue and one drain per cycle.
- When full, a store presented in the same cycle as a drain is refused. It is accepted in the next cycle.

## Configuration
- STORE_BUFFER_FWD_EN defined: LD_DATA carries the youngest matching entry's data. The pipeline uses it in place of memory data when LD_HIT=1.
- Not defined: the priority mux is omitted and LD_DATA is tied to 0. LD_HIT still reports any match, and the pipeline treats it as a load stall until the conflicting entries drain.

## Structure
- Shared package holds:
  - DEPTH default;
  - the PBITS derivation;
  - the entry struct type {valid, addr, data}.
- Sub-module sb_match: DEPTH-way address compare plus youngest-first priority select. Youngest is taken relative to tail. sb_match outputs the hit flag and the hit index.

## Test plan
- Reset, then one store: ST addr=0x010, data=0xDEADBEEF with MEM_GRANT=0 → COUNT=1 and LD_ADDR=0x010 gives LD_HIT=1, LD_DATA=0xDEADBEEF. Then raise MEM_GRANT → one cycle with MEM_WE=1, MEM_ADDR=0x010, MEM_DIN=0xDEADBEEF, then EMPTY=1.
- Fill: with MEM_GRANT=0, enqueue 4 stores to addresses 1–4 → ST_READY=0 at COUNT=4. A 5th store held for one cycle while MEM_GRANT=1 is accepted the following cycle. Memory receives addresses 1, 2, 3, 4, 5 in order.
- Same-address ordering: store 0x020←0x1 and then 0x020←0x2 with MEM_GRANT=0 → LD_DATA=0x2. Draining the first entry leaves LD_DATA=0x2.
- Wrap-around: stream 10 stores with MEM_GRANT=1 every cycle → each is written exactly one cycle after acceptance and COUNT never exceeds 1. Pointers wrap twice.
- Reset mid-operation: 3 entries pending, assert RESET for one cycle → EMPTY=1, COUNT=0, no MEM_WE, LD_HIT=0 for the old addresses.
- Without STORE_BUFFER_FWD_EN: a matching probe gives LD_HIT=1 and LD_DATA=0.
